// File: rtl/lanes_rx_merger.sv
`default_nettype none
// ============================================================================
// Module      : lanes_rx_merger
// Description : Captures one block per lane on each block strobe, checks and
//               strips the sync header, and merges both lane payloads into a
//               byte stream with valid/ready flow control. A two-entry
//               ping-pong buffer absorbs consumer back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module lanes_rx_merger #(
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       gen_speed,
  input  logic             block_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] lane_0_rx_parallel,
  input  logic [WIDTH-1:0] lane_1_rx_parallel,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_lane,
  output logic             sync_err,
  output logic             overflow
);

  // Stored payload excludes the two header bits common to both generations;
  // Gen3 payload then starts two bits further up.
  localparam int PW = WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_L0 = 2'd1,
    SEND_L1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         byte_cnt_q, byte_cnt_d;
  logic [1:0][PW-1:0] lane0_q, lane0_d, lane1_q, lane1_d;
  logic [1:0]         ok0_q, ok0_d, ok1_q, ok1_d, g3_q, g3_d, full_q, full_d;
  logic               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]         occ_q, occ_d;
  logic               sync_err_q, sync_err_d, overflow_q, overflow_d;

  logic               in_g3, in_ok0, in_ok1;
  logic               nxt_ptr, last_byte, accept, free_entry, capture;
  logic [PW-1:0]      cur_blk;
  logic [7:0]         cur_byte;

  function automatic logic hdr_ok(input logic [3:0] hdr, input logic g3);
    if (g3) return (hdr == 4'b0101) || (hdr == 4'b1010);
    else    return (hdr[1:0] == 2'b01) || (hdr[1:0] == 2'b10);
  endfunction

  assign in_g3   = (gen_speed != 2'b00);
  assign in_ok0  = hdr_ok(lane_0_rx_parallel[3:0], in_g3);
  assign in_ok1  = hdr_ok(lane_1_rx_parallel[3:0], in_g3);
  assign nxt_ptr = ~rd_ptr_q;

  // Select the byte currently presented from the head entry
  always_comb begin
    cur_blk  = (state_q == SEND_L1) ? lane1_q[rd_ptr_q] : lane0_q[rd_ptr_q];
    cur_byte = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (byte_cnt_q == 4'(k)) begin
        cur_byte = g3_q[rd_ptr_q] ? cur_blk[2+8*k +: 8] : cur_blk[8*k +: 8];
      end
    end
  end

  assign rx_valid = (state_q != IDLE);
  assign rx_lane  = (state_q == SEND_L1);
  assign rx_data  = rx_valid ? cur_byte : 8'h00;
  assign sync_err = sync_err_q;
  assign overflow = overflow_q;

  // Next-state: streaming FSM, entry release, capture and occupancy
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    lane0_d    = lane0_q;
    lane1_d    = lane1_q;
    ok0_d      = ok0_q;
    ok1_d      = ok1_q;
    g3_d       = g3_q;
    full_d     = full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    sync_err_d = 1'b0;
    overflow_d = 1'b0;
    free_entry = 1'b0;
    capture    = 1'b0;
    last_byte  = (byte_cnt_q == (g3_q[rd_ptr_q] ? 4'd15 : 4'd7));
    accept     = rx_valid && rx_ready;

    case (state_q)
      IDLE: begin
        if (full_q[rd_ptr_q]) begin
          byte_cnt_d = 4'd0;
          if (ok0_q[rd_ptr_q])      state_d = SEND_L0;
          else if (ok1_q[rd_ptr_q]) state_d = SEND_L1;
          else                      free_entry = 1'b1;
        end
      end
      SEND_L0: begin
        if (accept) begin
          if (last_byte) begin
            byte_cnt_d = 4'd0;
            if (ok1_q[rd_ptr_q]) state_d = SEND_L1;
            else                 free_entry = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      SEND_L1: begin
        if (accept) begin
          if (last_byte) begin
            byte_cnt_d = 4'd0;
            free_entry = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Releasing the head entry: jump straight into the next one if it is
    // already loaded so the stream has no bubble between block pairs.
    if (free_entry) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = nxt_ptr;
      state_d          = IDLE;
      if (full_q[nxt_ptr]) begin
        if (ok0_q[nxt_ptr])      state_d = SEND_L0;
        else if (ok1_q[nxt_ptr]) state_d = SEND_L1;
      end
    end

    // The write entry is always empty while occupancy is below two, so it
    // can never coincide with the entry being released this cycle.
    if (block_valid) begin
      if (occ_q != 2'd2) begin
        capture           = 1'b1;
        lane0_d[wr_ptr_q] = lane_0_rx_parallel[WIDTH-1:2];
        lane1_d[wr_ptr_q] = lane_1_rx_parallel[WIDTH-1:2];
        ok0_d[wr_ptr_q]   = in_ok0;
        ok1_d[wr_ptr_q]   = in_ok1;
        g3_d[wr_ptr_q]    = in_g3;
        full_d[wr_ptr_q]  = 1'b1;
        wr_ptr_d          = ~wr_ptr_q;
        sync_err_d        = !(in_ok0 && in_ok1);
      end else begin
        overflow_d = 1'b1;
      end
    end

    case ({capture, free_entry})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      state_d    = IDLE;
      byte_cnt_d = 4'd0;
      lane0_d    = '0;
      lane1_d    = '0;
      ok0_d      = '0;
      ok1_d      = '0;
      g3_d       = '0;
      full_d     = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
      sync_err_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // State and buffer registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= 4'd0;
      lane0_q    <= '0;
      lane1_q    <= '0;
      ok0_q      <= '0;
      ok1_q      <= '0;
      g3_q       <= '0;
      full_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lane0_q    <= lane0_d;
      lane1_q    <= lane1_d;
      ok0_q      <= ok0_d;
      ok1_q      <= ok1_d;
      g3_q       <= g3_d;
      full_q     <= full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lanes_rx_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_lanes_rx_merger
// Description : Directed scoreboard bench for lanes_rx_merger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lanes_rx_merger;
  localparam int WIDTH = 132;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       gen_speed = 2'b01;
  logic             block_valid = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] l0 = '0;
  logic [WIDTH-1:0] l1 = '0;
  logic             rx_ready = 1'b0;
  logic [7:0]       rx_data;
  logic             rx_valid, rx_lane, sync_err, overflow;

  lanes_rx_merger #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .gen_speed(gen_speed), .block_valid(block_valid),
    .flush(flush), .lane_0_rx_parallel(l0), .lane_1_rx_parallel(l1),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_lane(rx_lane), .sync_err(sync_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  int         sync_cnt = 0;
  int         ovf_cnt = 0;
  bit         hold_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] g3blk(input logic [7:0] base, input logic [3:0] hdr);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[4+8*k +: 8] = 8'(base + 8'(k));
    b[3:0] = hdr;
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] g2blk(input logic [7:0] base, input logic [1:0] hdr);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[2+8*k +: 8] = 8'(base + 8'(k));
    b[1:0] = hdr;
    return b;
  endfunction

  task automatic push_lane(input logic lane, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({lane, 8'(base + 8'(k))});
  endtask

  task automatic strobe(input logic [1:0] gen, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(posedge clk); #1;
    gen_speed = gen; l0 = a; l1 = b; block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk({name, "_idle"}, 32'(rx_valid), 32'd0);
  endtask

  // Monitor: pulse counters, hold-stability check and scoreboard compare
  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (sync_err) sync_cnt++;
      if (overflow) ovf_cnt++;
      if (hold_mode && prev_stall)
        chk("hold", 32'({rx_valid, rx_lane, rx_data}), 32'({1'b1, prev_out}));
      prev_stall = rx_valid && !rx_ready;
      prev_out   = {rx_lane, rx_data};
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte: unexpected lane=%0d data=%0h, expected none", rx_lane, rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'({rx_lane, rx_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_lane", 32'(rx_lane), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Gen3 good pair, latency and ordering
    @(posedge clk); #1;
    gen_speed = 2'b01; l0 = g3blk(8'h00, 4'b0101); l1 = g3blk(8'h10, 4'b0101);
    block_valid = 1'b1; rx_ready = 1'b1;
    push_lane(1'b0, 8'h00, 16);
    push_lane(1'b1, 8'h10, 16);
    @(negedge clk); chk("lat0", 32'(rx_valid), 32'd0);
    @(posedge clk); #1 block_valid = 1'b0;
    @(negedge clk); chk("lat1", 32'(rx_valid), 32'd0);
    @(negedge clk); chk("lat2", 32'(rx_valid), 32'd1);
    drain("t1");
    chk("t1_sync", 32'(sync_cnt), 32'd0);

    // Gen2, lane0 header bad, lane1 good
    sync_cnt = 0;
    push_lane(1'b1, 8'hA0, 8);
    strobe(2'b00, g2blk(8'h55, 2'b11), g2blk(8'hA0, 2'b10));
    drain("t2");
    chk("t2_sync", 32'(sync_cnt), 32'd1);

    // Back-pressure: two buffered, third dropped
    ovf_cnt = 0; sync_cnt = 0;
    rx_ready = 1'b0;
    push_lane(1'b0, 8'h20, 16); push_lane(1'b1, 8'h30, 16);
    push_lane(1'b0, 8'h40, 16); push_lane(1'b1, 8'h50, 16);
    strobe(2'b10, g3blk(8'h20, 4'b1010), g3blk(8'h30, 4'b0101));
    strobe(2'b11, g3blk(8'h40, 4'b0101), g3blk(8'h50, 4'b1010));
    strobe(2'b01, g3blk(8'h60, 4'b0101), g3blk(8'h70, 4'b0101));
    repeat (3) @(negedge clk);
    chk("t3_ovf", 32'(ovf_cnt), 32'd1);
    chk("t3_stall_out", 32'({rx_valid, rx_lane, rx_data}), 32'({1'b1, 1'b0, 8'h20}));
    @(posedge clk); #1 rx_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rx_valid) n++;
    end
    chk("t3_contiguous", 32'(n), 32'd64);
    drain("t3");
    chk("t3_sync", 32'(sync_cnt), 32'd0);

    // rx_ready toggling, every byte held until taken
    hold_mode = 1'b1;
    push_lane(1'b0, 8'h70, 16); push_lane(1'b1, 8'h80, 16);
    strobe(2'b01, g3blk(8'h70, 4'b0101), g3blk(8'h80, 4'b0101));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1 rx_ready = ~rx_ready;
      n++;
    end
    hold_mode = 1'b0;
    rx_ready = 1'b1;
    drain("t4");

    // Flush mid lane 1 together with block_valid
    ovf_cnt = 0; sync_cnt = 0;
    push_lane(1'b0, 8'h90, 16); push_lane(1'b1, 8'hA0, 16);
    strobe(2'b01, g3blk(8'h90, 4'b0101), g3blk(8'hA0, 4'b0101));
    n = 0;
    while (!rx_lane && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_l1", 32'(rx_lane), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1; block_valid = 1'b1; rx_ready = 1'b0;
    l0 = g3blk(8'hB0, 4'b0101); l1 = g3blk(8'hB0, 4'b0101);
    exp_q.delete();
    @(posedge clk); #1 flush = 1'b0; block_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(rx_valid), 32'd0);
    chk("t5_data", 32'(rx_data), 32'd0);
    repeat (4) @(negedge clk);
    chk("t5_no_capture", 32'(rx_valid), 32'd0);
    chk("t5_flags", 32'({ovf_cnt[15:0], sync_cnt[15:0]}), 32'd0);
    rx_ready = 1'b1;
    push_lane(1'b0, 8'hC0, 16); push_lane(1'b1, 8'hD0, 16);
    strobe(2'b01, g3blk(8'hC0, 4'b0101), g3blk(8'hD0, 4'b0101));
    drain("t5");

    // Asynchronous reset mid-stream
    push_lane(1'b0, 8'hE0, 16); push_lane(1'b1, 8'hF0, 16);
    strobe(2'b01, g3blk(8'hE0, 4'b0101), g3blk(8'hF0, 4'b0101));
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_valid", 32'(rx_valid), 32'd0);
    chk("t6_data", 32'(rx_data), 32'd0);
    chk("t6_lane", 32'(rx_lane), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_lane(1'b0, 8'h01, 16); push_lane(1'b1, 8'h41, 16);
    strobe(2'b11, g3blk(8'h01, 4'b1010), g3blk(8'h41, 4'b1010));
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
